// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIF butterfly: fft_a = a + b, fft_b = (a - b) * W_N^k, with ROM twiddles, IFFT conjugate, /2 scaling, saturation.
// Latency: 3 cycles from input handshake to out_valid; throughput one pair per cycle.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready is the combinational inverse of that stall.
//
// Ports: clk/rst (synchronous, active-high); in_valid/in_ready with operands a, b (packed {re,im}),
//        twiddle index power, inverse, scale; out_valid/out_ready with results fft_a, fft_b;
//        ovf sticky saturation flag cleared by clr_ovf.
// Optional: define FFT_BFLY_STATS_EN to add bfly_cnt[15:0], a wrapping count of results handed off.
module fft_bfly_pipe #(
    parameter int DW    = 16,
    parameter int LOG2N = 4,
    parameter int TW    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   a,
    input  logic [2*DW-1:0]   b,
    input  logic [LOG2N-2:0]  power,
    input  logic              inverse,
    input  logic              scale,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   fft_a,
    output logic [2*DW-1:0]   fft_b,
    output logic              ovf,
    input  logic              clr_ovf
`ifdef FFT_BFLY_STATS_EN
    ,
    output logic [15:0]       bfly_cnt
`endif
);

    localparam int N    = 1 << LOG2N;
    localparam int NH   = N / 2;
    localparam int FRAC = 16;            // twiddle fractional bits
    localparam int SW   = DW + 1;        // sum/difference width
    localparam int PW   = SW + TW;       // product width
    localparam int RW   = PW + 2;        // product sum plus rounding headroom
    localparam logic signed [RW-1:0] MAXV = RW'((1 << (DW - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

    // Truncated-magnitude twiddle: re = cos, im = -sin, evaluated at elaboration.
    function automatic logic signed [TW-1:0] tw_val(input int k, input bit im);
        real th;
        real v;
        int  mag;
        th  = 2.0 * 3.14159265358979323846 * k / N;
        v   = im ? -$sin(th) : $cos(th);
        mag = $rtoi(((v < 0.0) ? -v : v) * 65536.0);
        return (v < 0.0) ? TW'(-mag) : TW'(mag);
    endfunction

    // Round half toward +inf, then arithmetic shift right.
    function automatic logic signed [RW-1:0] rnd_shift(input logic signed [RW-1:0] v, input int sh);
        logic signed [RW-1:0] half;
        half = (sh == 0) ? '0 : (RW'(1) <<< (sh - 1));
        return (v + half) >>> sh;
    endfunction

    // Returns {clipped, value} clamped to the DW-bit signed range.
    function automatic logic [DW:0] sat(input logic signed [RW-1:0] v);
        if (v > MAXV) return {1'b1, MAXV[DW-1:0]};
        if (v < MINV) return {1'b1, MINV[DW-1:0]};
        return {1'b0, v[DW-1:0]};
    endfunction

    logic signed [TW-1:0] rom_wr [NH];
    logic signed [TW-1:0] rom_wi [NH];

    for (genvar g = 0; g < NH; g++) begin : g_rom
        localparam logic signed [TW-1:0] WR = tw_val(g, 1'b0);
        localparam logic signed [TW-1:0] WI = tw_val(g, 1'b1);
        assign rom_wr[g] = WR;
        assign rom_wi[g] = WI;
    end

    logic stall;

    // Stage 1: sum/difference and captured controls
    logic                 s1_vld_q;
    logic signed [SW-1:0] s1_sr_q, s1_si_q, s1_dr_q, s1_di_q;
    logic signed [SW-1:0] s1_sr_d, s1_si_d, s1_dr_d, s1_di_d;
    logic signed [TW-1:0] s1_wr_q, s1_wi_q, s1_wi_d;
    logic                 s1_sc_q;

    // Stage 2: products, sums carried forward
    logic                 s2_vld_q;
    logic signed [SW-1:0] s2_sr_q, s2_si_q;
    logic signed [PW-1:0] s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
    logic signed [PW-1:0] s2_rr_d, s2_ii_d, s2_ri_d, s2_ir_d;
    logic                 s2_sc_q;

    // Stage 3: output registers
    logic                 out_vld_q;
    logic [2*DW-1:0]      fa_q, fb_q, fa_d, fb_d;
    logic                 ovf_q, ovf_d, clip_d;

    logic signed [RW-1:0] re_b, im_b;
    logic [DW:0]          sat_ar, sat_ai, sat_br, sat_bi;
    int                   sc;

    assign stall     = out_vld_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_vld_q;
    assign fft_a     = fa_q;
    assign fft_b     = fb_q;
    assign ovf       = ovf_q;

    always_comb begin
        s1_sr_d = {a[2*DW-1], a[2*DW-1:DW]} + {b[2*DW-1], b[2*DW-1:DW]};
        s1_si_d = {a[DW-1], a[DW-1:0]} + {b[DW-1], b[DW-1:0]};
        s1_dr_d = {a[2*DW-1], a[2*DW-1:DW]} - {b[2*DW-1], b[2*DW-1:DW]};
        s1_di_d = {a[DW-1], a[DW-1:0]} - {b[DW-1], b[DW-1:0]};
        // IFFT uses conj(W): only the imaginary twiddle flips sign
        s1_wi_d = inverse ? -rom_wi[power] : rom_wi[power];

        s2_rr_d = PW'(s1_dr_q) * PW'(s1_wr_q);
        s2_ii_d = PW'(s1_di_q) * PW'(s1_wi_q);
        s2_ri_d = PW'(s1_dr_q) * PW'(s1_wi_q);
        s2_ir_d = PW'(s1_di_q) * PW'(s1_wr_q);

        sc     = int'(s2_sc_q);
        re_b   = RW'(s2_rr_q) - RW'(s2_ii_q);
        im_b   = RW'(s2_ri_q) + RW'(s2_ir_q);
        sat_ar = sat(rnd_shift(RW'(s2_sr_q), sc));
        sat_ai = sat(rnd_shift(RW'(s2_si_q), sc));
        sat_br = sat(rnd_shift(re_b, FRAC + sc));
        sat_bi = sat(rnd_shift(im_b, FRAC + sc));
        fa_d   = {sat_ar[DW-1:0], sat_ai[DW-1:0]};
        fb_d   = {sat_br[DW-1:0], sat_bi[DW-1:0]};
        clip_d = sat_ar[DW] | sat_ai[DW] | sat_br[DW] | sat_bi[DW];

        // A clamp landing in the output register wins over a same-cycle clear
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (!stall && s2_vld_q && clip_d) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sr_q   <= '0;
            s1_si_q   <= '0;
            s1_dr_q   <= '0;
            s1_di_q   <= '0;
            s1_wr_q   <= '0;
            s1_wi_q   <= '0;
            s1_sc_q   <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_sr_q   <= '0;
            s2_si_q   <= '0;
            s2_rr_q   <= '0;
            s2_ii_q   <= '0;
            s2_ri_q   <= '0;
            s2_ir_q   <= '0;
            s2_sc_q   <= 1'b0;
            out_vld_q <= 1'b0;
            fa_q      <= '0;
            fb_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (!stall) begin
                s1_vld_q  <= in_valid;
                s1_sr_q   <= s1_sr_d;
                s1_si_q   <= s1_si_d;
                s1_dr_q   <= s1_dr_d;
                s1_di_q   <= s1_di_d;
                s1_wr_q   <= rom_wr[power];
                s1_wi_q   <= s1_wi_d;
                s1_sc_q   <= scale;
                s2_vld_q  <= s1_vld_q;
                s2_sr_q   <= s1_sr_q;
                s2_si_q   <= s1_si_q;
                s2_rr_q   <= s2_rr_d;
                s2_ii_q   <= s2_ii_d;
                s2_ri_q   <= s2_ri_d;
                s2_ir_q   <= s2_ir_d;
                s2_sc_q   <= s1_sc_q;
                out_vld_q <= s2_vld_q;
                // Outputs hold their last result across bubbles
                if (s2_vld_q) begin
                    fa_q <= fa_d;
                    fb_q <= fb_d;
                end
            end
            ovf_q <= ovf_d;
        end
    end

`ifdef FFT_BFLY_STATS_EN
    logic [15:0] cnt_q;
    assign bfly_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_vld_q && out_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed and randomized checks of fft_bfly_pipe against an arithmetic reference model.
// Reference model computes each result at input handshake and matches it at output handoff.
// Drives inputs on the falling edge and observes outputs just after it.
module tb_fft_bfly_pipe;

    localparam int DW = 16;
    localparam int LOG2N = 4;
    localparam int TW = 18;
    localparam int NPT = 1 << LOG2N;

    typedef struct packed {
        logic [31:0] fa;
        logic [31:0] fb;
        logic        clip;
    } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, inverse, scale, out_valid, out_ready, ovf, clr_ovf;
    logic [31:0] a, b, fft_a, fft_b;
    logic [LOG2N-2:0] power;
`ifdef FFT_BFLY_STATS_EN
    logic [15:0] bfly_cnt;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    int   hcnt   = 0;
    logic exp_ovf = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    fft_bfly_pipe #(.DW(DW), .LOG2N(LOG2N), .TW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .power(power), .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready), .fft_a(fft_a), .fft_b(fft_b),
        .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef FFT_BFLY_STATS_EN
        , .bfly_cnt(bfly_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Round half toward +inf of x / 2^sh, using floor division
    function automatic longint rsh(input longint x, input int sh);
        longint d, y, qt;
        d  = longint'(1) << sh;
        y  = x + d / 2;
        qt = y / d;
        if (y < 0 && qt * d != y) qt = qt - 1;
        return qt;
    endfunction

    function automatic logic [16:0] sat16(input longint v);
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(v)};
    endfunction

    function automatic exp_t model(input logic [31:0] a_, input logic [31:0] b_,
                                   input int pw, input logic inv, input logic sc);
        longint ar, ai, br, bi, dr, di, wr, wi, vre, vim;
        real th, c, s;
        logic [16:0] r0, r1, r2, r3;
        exp_t e;
        ar = longint'($signed(a_[31:16]));
        ai = longint'($signed(a_[15:0]));
        br = longint'($signed(b_[31:16]));
        bi = longint'($signed(b_[15:0]));
        th = 2.0 * 3.14159265358979323846 * pw / NPT;
        c  = $cos(th);
        s  = $sin(th);
        wr = longint'($floor(((c < 0.0) ? -c : c) * 65536.0));
        if (c < 0.0) wr = -wr;
        wi = longint'($floor(((s < 0.0) ? -s : s) * 65536.0));
        if (s > 0.0) wi = -wi;
        if (inv) wi = -wi;
        dr  = ar - br;
        di  = ai - bi;
        vre = dr * wr - di * wi;
        vim = dr * wi + di * wr;
        r0 = sat16(rsh(ar + br, int'(sc)));
        r1 = sat16(rsh(ai + bi, int'(sc)));
        r2 = sat16(rsh(vre, 16 + int'(sc)));
        r3 = sat16(rsh(vim, 16 + int'(sc)));
        e.fa   = {r0[15:0], r1[15:0]};
        e.fb   = {r2[15:0], r3[15:0]};
        e.clip = r0[16] | r1[16] | r2[16] | r3[16];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a_, input logic [31:0] b_,
                         input int pw, input logic inv, input logic sc);
        in_valid = v;
        a        = a_;
        b        = b_;
        power    = (LOG2N - 1)'(pw);
        inverse  = inv;
        scale    = sc;
    endtask

    // One cycle: observe handshakes after settling, cross the rising edge, return at falling edge
    task automatic step(output bit acc);
        exp_t e;
        #1;
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                hcnt++;
                exp_ovf = exp_ovf | e.clip;
                chk("fft_a", fft_a, e.fa);
                chk("fft_b", fft_b, e.fb);
                chk("ovf", ovf, exp_ovf);
            end
        end
        acc = in_valid && in_ready && !rst;
        if (acc) q.push_back(model(a, b, int'(power), inverse, scale));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_one(input logic [31:0] a_, input logic [31:0] b_,
                           input int pw, input logic inv, input logic sc);
        bit acc;
        int lat;
        drive(1'b1, a_, b_, pw, inv, sc);
        step(acc);
        drive(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step(acc);
            lat++;
        end
        chk("latency", lat, 3);
        step(acc);
    endtask

    task automatic clear_ovf();
        bit acc;
        clr_ovf = 1'b1;
        step(acc);
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);
    endtask

    task automatic drain();
        bit acc;
        int n;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 30) begin
            step(acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic logic [15:0] rsmall();
        logic [15:0] x;
        x = 16'($urandom_range(0, 8191));
        return x - 16'd4096;
    endfunction

    initial begin
        bit acc;
        int idx, cyc, stalls;
        logic [31:0] va[6];
        logic [31:0] vb[6];

        rst = 1'b1;
        out_ready = 1'b1;
        clr_ovf = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fft_a", fft_a, 32'd0);
        chk("rst_fft_b", fft_b, 32'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef FFT_BFLY_STATS_EN
        chk("rst_cnt", bfly_cnt, 32'd0);
`endif
        @(negedge clk);

        // Directed cases with hand-derived results
        run_one(32'h0100_0000, 32'h0080_0000, 0, 1'b0, 1'b0);
        chk("ident_a", fft_a, 32'h0180_0000);
        chk("ident_b", fft_b, 32'h0080_0000);
        chk("ident_ovf", ovf, 1'b0);
        run_one(32'h0100_0000, 32'h0, 4, 1'b0, 1'b0);
        chk("negj_b", fft_b, 32'h0000_FF00);
        run_one(32'h0100_0000, 32'h0, 4, 1'b1, 1'b0);
        chk("inv_b", fft_b, 32'h0000_0100);
        run_one(32'h0100_0000, 32'h0, 2, 1'b0, 1'b0);
        chk("round_b", fft_b, 32'h00B5_FF4B);
        run_one(32'h7FFF_8000, 32'h7FFF_8000, 0, 1'b0, 1'b0);
        chk("sat_a", fft_a, 32'h7FFF_8000);
        chk("sat_b", fft_b, 32'h0);
        chk("sat_ovf", ovf, 1'b1);
        clear_ovf();
        run_one(32'h7FFF_8000, 32'h7FFF_8000, 0, 1'b0, 1'b1);
        chk("scale_a", fft_a, 32'h7FFF_8000);
        chk("scale_ovf", ovf, 1'b0);

        // Backpressure: six random pairs, out_ready low for four cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            va[i] = {rsmall(), rsmall()};
            vb[i] = {rsmall(), rsmall()};
        end
        idx = 0;
        cyc = 0;
        stalls = 0;
        while ((idx < 6 || q.size() != 0) && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            if (idx < 6) drive(1'b1, va[idx], vb[idx], idx, idx[0], 1'b0);
            else         drive(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
            #1;
            if (out_valid && !out_ready) stalls++;
            step(acc);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_accepted", idx, 6);
        chk("bp_stalls", stalls, 4);
        chk("bp_empty", q.size(), 0);
`ifdef FFT_BFLY_STATS_EN
        chk("bp_cnt", bfly_cnt, 32'(hcnt));
`endif

        // Random traffic: small operands first (no clamps), then full range
        for (int ph = 0; ph < 2; ph++) begin
            clear_ovf();
            for (int c = 0; c < 150; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (ph == 0)
                    drive($urandom_range(0, 3) != 0, {rsmall(), rsmall()}, {rsmall(), rsmall()},
                          $urandom_range(0, NPT / 2 - 1), 1'($urandom), 1'($urandom));
                else
                    drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                          $urandom_range(0, NPT / 2 - 1), 1'($urandom), 1'($urandom));
                step(acc);
            end
            drain();
        end
`ifdef FFT_BFLY_STATS_EN
        chk("rand_cnt", bfly_cnt, 32'(hcnt));
`endif

        // Reset with three clamping results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7FFF_8000, 32'h7FFF_8000, i, 1'b0, 1'b0);
            step(acc);
        end
        drive(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_ovf", ovf, 1'b1);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        hcnt = 0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        chk("midrst_fft_a", fft_a, 32'd0);
`ifdef FFT_BFLY_STATS_EN
        chk("midrst_cnt", bfly_cnt, 32'd0);
`endif
        out_ready = 1'b1;
        repeat (6) step(acc);
        chk("post_rst_idle", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
